// File: rtl/pc_gen.sv
// Fetch program-counter stage: holds the fetch PC and predicts its successor
// (JAL always taken, conditional branches via a bimodal table, JALR falls through).
module pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] inst,
  input  logic        is_jump,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        is_branch,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pred_taken
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  typedef logic [BHT_IDX_W-1:0] bht_idx_t;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [1:0]  bht_reg  [BHT_N];
  logic [1:0]  bht_next [BHT_N];

  logic        dec_br;
  logic        dec_jal;
  logic        dec_jalr;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] pc_plus4;
  logic [31:0] pc_br_tgt;
  logic [31:0] pc_jal_tgt;
  bht_idx_t    fetch_idx;
  bht_idx_t    resolve_idx;
  logic [1:0]  fetch_ctr;

  // Decode, qualified by the jump-class hint.
  assign dec_br   = is_jump & is_branch;
  assign dec_jal  = is_jump & is_jal;
  assign dec_jalr = is_jump & is_jalr;

  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // All adds wrap modulo 2^32.
  assign pc_plus4   = pc_reg + 32'd4;
  assign pc_br_tgt  = pc_reg + imm_b;
  assign pc_jal_tgt = pc_reg + imm_j;

  assign fetch_idx   = pc_reg[BHT_IDX_W+1:2];
  assign resolve_idx = resolve_pc[BHT_IDX_W+1:2];
  // Reads the pre-update counter; a same-cycle resolve is seen next cycle.
  assign fetch_ctr   = bht_reg[fetch_idx];

  always_comb begin
    pred_taken = 1'b0;
    next_pc    = pc_plus4;
    if (dec_jal) begin
      pred_taken = 1'b1;
      next_pc    = pc_jal_tgt;
    end else if (dec_br && !dec_jalr) begin
      pred_taken = fetch_ctr[1];
      next_pc    = fetch_ctr[1] ? pc_br_tgt : pc_plus4;
    end
  end

  always_comb begin
    pc_next = next_pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (stall) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // Per-entry saturating counter update; training ignores stall and redirect.
  generate
    for (genvar gi = 0; gi < BHT_N; gi++) begin : g_bht
      always_comb begin
        bht_next[gi] = bht_reg[gi];
        if (resolve_valid && (resolve_idx == bht_idx_t'(gi))) begin
          if (resolve_taken) begin
            if (bht_reg[gi] != 2'd3) begin
              bht_next[gi] = bht_reg[gi] + 2'd1;
            end
          end else begin
            if (bht_reg[gi] != 2'd0) begin
              bht_next[gi] = bht_reg[gi] - 2'd1;
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < BHT_N; i++) begin
      if (!rst_n) begin
        bht_reg[i] <= 2'd1;
      end else begin
        bht_reg[i] <= bht_next[i];
      end
    end
  end

  assign pc = pc_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expectations are queued per step and drained
// against the DUT outputs at the falling edge.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] inst;
  logic        is_jump;
  logic        is_jal;
  logic        is_jalr;
  logic        is_branch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pred_taken;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          kind;  // 0 = pc, 1 = next_pc, 2 = pred_taken
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  pc_gen #(.RESET_PC(32'h0000_0000), .BHT_IDX_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .inst           (inst),
    .is_jump        (is_jump),
    .is_jal         (is_jal),
    .is_jalr        (is_jalr),
    .is_branch      (is_branch),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resolve_valid  (resolve_valid),
    .resolve_pc     (resolve_pc),
    .resolve_taken  (resolve_taken),
    .pc             (pc),
    .next_pc        (next_pc),
    .pred_taken     (pred_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within its time budget");
    $fatal(1, "timeout");
  end

  task automatic exp_pc(input string tag, input logic [31:0] v);
    sb.push_back('{tag, 0, v});
  endtask

  task automatic exp_comb(input string tag, input logic [31:0] nx, input logic p);
    sb.push_back('{tag, 1, nx});
    sb.push_back('{tag, 2, {31'd0, p}});
  endtask

  task automatic check_now();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = pc;
        1:       obs = next_pc;
        default: obs = {31'd0, pred_taken};
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s kind=%0d observed=%h expected=%h", e.tag, e.kind, obs, e.val);
      end
      $display("check %-18s kind=%0d pc=%h observed=%h expected=%h", e.tag, e.kind, pc, obs, e.val);
    end
  endtask

  task automatic set_nonjump();
    inst = 32'h0000_0013; is_jump = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; is_branch = 1'b0;
  endtask

  task automatic set_jal();
    inst = 32'h0080_006F; is_jump = 1'b1; is_jal = 1'b1; is_jalr = 1'b0; is_branch = 1'b0;
  endtask

  task automatic set_br();
    inst = 32'hFE00_0CE3; is_jump = 1'b1; is_jal = 1'b0; is_jalr = 1'b0; is_branch = 1'b1;
  endtask

  task automatic resolve(input logic v, input logic [31:0] rpc, input logic t);
    resolve_valid = v; resolve_pc = rpc; resolve_taken = t;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    resolve(1'b0, 32'd0, 1'b0);
    set_nonjump();

    // Reset, then sequential fetch
    repeat (2) @(negedge clk);
    #1; exp_pc("rst_pc", 32'h0); exp_comb("rst_comb", 32'h4, 1'b0); check_now();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      exp_pc("seq_pc", 32'(4 * k)); exp_comb("seq_comb", 32'(4 * k + 4), 1'b0); check_now();
    end

    // JAL at 0x10
    set_jal(); #1;
    exp_comb("jal_pred", 32'h18, 1'b1); check_now();
    @(negedge clk); set_nonjump(); #1;
    exp_pc("jal_tgt", 32'h18); check_now();
    @(negedge clk);
    @(negedge clk); #1;
    exp_pc("walk_to_20", 32'h20); check_now();

    // Branch at 0x20, stalled; resolve in the same cycle sees the old counter
    set_br(); stall = 1'b1; resolve(1'b1, 32'h20, 1'b1); #1;
    exp_comb("br_same_idx", 32'h24, 1'b0); check_now();
    @(negedge clk); resolve(1'b0, 32'h0, 1'b0); #1;
    exp_pc("br_stall_hold", 32'h20); exp_comb("br_ctr2", 32'h18, 1'b1); check_now();
    resolve(1'b1, 32'h20, 1'b1);
    repeat (2) @(negedge clk);
    resolve(1'b1, 32'h20, 1'b0);
    @(negedge clk); resolve(1'b0, 32'h0, 1'b0); #1;
    exp_comb("br_sat_then_nt", 32'h18, 1'b1); check_now();

    // Taken prediction is zero-bubble
    stall = 1'b0;
    @(negedge clk); set_nonjump(); #1;
    exp_pc("br_taken_pc", 32'h18); check_now();
    @(negedge clk);
    @(negedge clk); set_br(); stall = 1'b1; resolve(1'b1, 32'h20, 1'b0); #1;
    exp_pc("back_at_20", 32'h20); exp_comb("br_ctr2_again", 32'h18, 1'b1); check_now();
    @(negedge clk); resolve(1'b0, 32'h0, 1'b0); #1;
    exp_comb("br_ctr1", 32'h24, 1'b0); check_now();

    // Training a different index leaves 0x20 alone
    resolve(1'b1, 32'h64, 1'b1);
    @(negedge clk); resolve(1'b0, 32'h0, 1'b0); #1;
    exp_comb("br_other_idx", 32'h24, 1'b0); check_now();

    // Redirect overrides stall; then stall holds while the table trains
    set_nonjump(); redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk); redirect_valid = 1'b0; #1;
    exp_pc("redir_over_stall", 32'h40); check_now();
    resolve(1'b1, 32'h20, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); resolve(1'b0, 32'h0, 1'b0); #1;
      exp_pc("stall_hold", 32'h40); check_now();
    end

    // Wrap-around
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); redirect_valid = 1'b0; #1;
    exp_pc("wrap_redir", 32'hFFFF_FFFC); exp_comb("wrap_next", 32'h0, 1'b0); check_now();
    @(negedge clk); #1;
    exp_pc("wrap_pc", 32'h0); check_now();

    // Training done while stalled is visible
    redirect_valid = 1'b1; redirect_pc = 32'h20; stall = 1'b1;
    @(negedge clk); redirect_valid = 1'b0; set_br(); #1;
    exp_pc("redir_20", 32'h20); exp_comb("stall_trained", 32'h18, 1'b1); check_now();

    // Reset during redirect and resolve
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; resolve(1'b1, 32'h20, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; redirect_valid = 1'b0; resolve(1'b0, 32'h0, 1'b0); set_nonjump(); #1;
    exp_pc("rst_mid", 32'h0); exp_comb("rst_mid_comb", 32'h4, 1'b0); check_now();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge clk); redirect_valid = 1'b0; set_br(); #1;
    exp_pc("rst_redir_20", 32'h20); exp_comb("rst_bht_cleared", 32'h24, 1'b0); check_now();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generation stage sitting directly upstream of instruction fetch. It holds the architectural fetch PC and drives it combinationally into fetch. From the instruction and jump-class hints that fetch returns in the same cycle, it computes a predicted next PC: JAL is always taken, conditional branches use a 2-bit bimodal history table, and JALR falls through. Execute-stage redirects override the prediction, and resolved branches train the table.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- BHT_IDX_W, 4, log2 of the branch-history-table entry count (16 entries). Indexed by pc[BHT_IDX_W+1:2].

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on clk rising edge.
- stall  input  1  hold pc (downstream not ready).
- inst  input  32  instruction fetched at the current pc.
- is_jump  input  1  inst is a jump-class opcode (110xx11).
- is_jal  input  1  inst bit 3; meaningful only with is_jump.
- is_jalr  input  1  inst bit 2; meaningful only with is_jump.
- is_branch  input  1  ~is_jal & ~is_jalr; meaningful only with is_jump.
- redirect_valid  input  1  execute detected a mispredict or needs a flush.
- redirect_pc  input  32  corrected PC.
- resolve_valid  input  1  a conditional branch resolved this cycle.
- resolve_pc  input  32  PC of the resolved branch.
- resolve_taken  input  1  actual branch outcome.
- pc  output  32  registered fetch PC.
- next_pc  output  32  combinational predicted successor of pc.
- pred_taken  output  1  combinational; current inst is predicted to redirect flow.

## Operation
- Instruction decode, qualified by is_jump:
  - br = is_jump & is_branch
  - jal = is_jump & is_jal
  - jalr = is_jump & is_jalr
- Immediates, sign-extended to 32 bits:
  - B-imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - J-imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
- Prediction:
  - jal: pred_taken=1, next_pc = pc + J-imm.
  - br: pred_taken = bht[idx(pc)][1]; next_pc = pc + B-imm if taken, else pc + 4.
  - jalr or non-jump: pred_taken=0, next_pc = pc + 4.
- All adds are modulo 2^32: wrap-around is silent, no overflow flag.
- pc register update, in priority order:
  1. !rst_n → RESET_PC.
  2. redirect_valid → redirect_pc. Overrides stall.
  3. stall → hold.
  4. otherwise → next_pc.
- BHT: 2^BHT_IDX_W entries of 2-bit saturating counters.
  - States 0 (strong NT), 1 (weak NT), 2 (weak T), 3 (strong T).
  - On resolve_valid, entry idx(resolve_pc) increments if resolve_taken, else decrements, saturating at 3 and 0.
  - Updates are independent of stall and redirect.
  - Reset: all entries = 1, synchronous with rst_n low.
- redirect_pc and the low 2 bits of pc are not checked or forced to alignment; they pass through unchanged.

## Timing
- Reset values: pc = RESET_PC; all BHT entries = 1. next_pc and pred_taken are combinational from pc, inst and the BHT, so they are valid whenever inst is valid.
- Latency: redirect_valid at edge N makes pc = redirect_pc after edge N; one-cycle redirect penalty.
- Prediction is zero-bubble: next_pc computed in cycle N becomes pc at edge N+1 when not stalled.
- Simultaneous BHT read and write to the same index: the prediction read uses the pre-update counter, and the new value is visible the following cycle.
- rst_n low mid-operation, including while stalled or redirecting, wins on that edge and also clears the BHT.
- A resolve arriving in the same cycle as rst_n low is dropped.
- stall held for many cycles: pc constant; BHT still trains.

## Test plan
- Reset/sequential: hold rst_n=0 for 2 cycles, then feed non-jump inst (addi, 0x00000013) → pc = 0, 4, 8, 12 on successive edges; pred_taken=0.
- JAL: at pc=0x10 feed inst 0x0080006F (jal x0, +8), is_jump=1, is_jal=1 → pred_taken=1, next_pc=0x18, pc=0x18 next cycle.
- Branch training: at pc=0x20, backward beq with B-imm -8 (0xFE000CE3).
  - Initially: pred_taken=0, next_pc=0x24.
  - After one resolve (0x20, taken): counter 2, pred_taken=1, next_pc=0x18.
  - After two more taken resolves: counter stays 3.
  - After one not-taken resolve: counter 2, still predicted taken.
- Redirect vs stall: stall=1 and redirect_valid=1 with redirect_pc=0x40 in the same cycle → pc=0x40 next edge. Then stall=1 alone for 3 cycles → pc stays 0x40.
- Same-index read/update: resolve (0x20, taken) in the same cycle pc=0x20 with counter 1 → that cycle pred_taken=0; the next time pc=0x20, pred_taken=1.
- Wrap/reset mid-run:
  - redirect to 0xFFFFFFFC with a non-jump inst → next pc = 0x00000000.
  - Assert rst_n=0 during an active redirect → pc=RESET_PC and all counters = 1.
